wgt_path_loader: RTL and testbench

- Transmitter for the weight-path shift chain of the systolic array.
- Accepts one weight row per valid/ready beat and drives the top PE of every column: b_path_in, b_path_en_in, b_en_in.
- After ROWS rows it issues a one-cycle commit (b_en) so every PE moves its path weight into its active weight register.
- Supports back-to-back tiles without bubbles, gated by the array controller.

---
 rtl/wgt_array_pkg.sv | 19 +
 rtl/wgt_path_pipe.sv | 47 ++++
 rtl/wgt_path_loader.sv | 97 +++++++++
 tb/tb_wgt_path_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_array_pkg.sv
// Shared types and helpers for the weight-path loader and its delay line.
// Revision 1.0
`default_nettype none

package wgt_array_pkg;

    localparam int WGT_DATA_WIDTH_DEF = 8;
    localparam int COLS_DEF           = 4;

    typedef logic [COLS_DEF*WGT_DATA_WIDTH_DEF-1:0] wgt_row_t;

    // Row counter needs at least one bit even for single-row tiles.
    function automatic int row_cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wgt_path_pipe.sv
// Two-stage data / one-stage enable delay line feeding the row-0 PEs.
// Revision 1.0
`default_nettype none

module wgt_path_pipe
    import wgt_array_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COLS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] path_data,
    output logic [COLS-1:0]       path_en,
    output logic                  path_en_any
);

    logic [DATA_WIDTH-1:0] r_stage;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_en;

    // Output data only advances behind an enable so the PE chain sees a stable hold value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
        end else begin
            r_en <= in_valid;
            if (in_valid) begin
                r_stage <= in_data;
            end
            if (r_en) begin
                r_data <= r_stage;
            end
        end
    end

    assign path_data   = r_data;
    assign path_en     = {COLS{r_en}};
    assign path_en_any = r_en;

endmodule

`default_nettype wire

// File: rtl/wgt_path_loader.sv
// Weight-path shift-chain transmitter with tile commit; optional stall counter via WGT_PATH_LOADER_STALL_CNT_EN.
// Revision 1.0
`default_nettype none

module wgt_path_loader
    import wgt_array_pkg::*;
#(
    parameter int WGT_DATA_WIDTH = 8,
    parameter int ROWS           = 4,
    parameter int COLS           = 4
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
    output logic [31:0]                    stall_cnt,
`endif
    input  logic                           wgt_valid,
    output logic                           wgt_ready,
    input  logic [COLS*WGT_DATA_WIDTH-1:0] wgt_data,
    input  logic                           commit_allow,
    output logic [COLS*WGT_DATA_WIDTH-1:0] b_path_out,
    output logic [COLS-1:0]                b_path_en_out,
    output logic [COLS-1:0]                b_en_out,
    output logic                           busy,
    output logic                           tile_done
);

    localparam int CNT_W = row_cnt_width(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0] r_row_cnt;
    logic             r_pending;
    logic             r_commit;
    logic             w_accept;
    logic             w_last;
    logic             w_commit_go;
    logic             w_path_en;

    assign wgt_ready   = !reset && (!r_pending || commit_allow);
    assign w_accept    = wgt_valid && wgt_ready;
    assign w_last      = (r_row_cnt == LAST_ROW);
    assign w_commit_go = r_pending && commit_allow;

    // A tile completing in the same cycle its predecessor commits keeps pending set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_cnt <= '0;
            r_pending <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= w_commit_go;
            if (w_accept) begin
                r_row_cnt <= w_last ? '0 : r_row_cnt + CNT_W'(1);
            end
            if (w_accept && w_last) begin
                r_pending <= 1'b1;
            end else if (w_commit_go) begin
                r_pending <= 1'b0;
            end
        end
    end

    wgt_path_pipe #(
        .DATA_WIDTH (COLS*WGT_DATA_WIDTH),
        .COLS       (COLS)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (w_accept),
        .in_data     (wgt_data),
        .path_data   (b_path_out),
        .path_en     (b_path_en_out),
        .path_en_any (w_path_en)
    );

    assign b_en_out  = {COLS{r_commit}};
    assign tile_done = r_commit;
    assign busy      = (r_row_cnt != '0) || r_pending || w_path_en;

`ifdef WGT_PATH_LOADER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts starvation and commit back-pressure while a tile is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (busy && !w_accept && !w_commit_go && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wgt_path_loader.sv
// Scoreboard bench for wgt_path_loader driving a ROWSxCOLS PE-array model.
// Revision 1.0
`default_nettype none

module tb_wgt_path_loader;

    localparam int W    = 8;
    localparam int ROWS = 4;
    localparam int COLS = 2;
    localparam int DW   = COLS*W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wgt_valid = 1'b0;
    logic          wgt_ready;
    logic [DW-1:0] wgt_data = '0;
    logic          commit_allow = 1'b1;
    logic [DW-1:0] b_path_out;
    logic [COLS-1:0] b_path_en_out;
    logic [COLS-1:0] b_en_out;
    logic          busy;
    logic          tile_done;
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    wgt_path_loader #(.WGT_DATA_WIDTH(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .wgt_valid     (wgt_valid),
        .wgt_ready     (wgt_ready),
        .wgt_data      (wgt_data),
        .commit_allow  (commit_allow),
        .b_path_out    (b_path_out),
        .b_path_en_out (b_path_en_out),
        .b_en_out      (b_en_out),
        .busy          (busy),
        .tile_done     (tile_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; logic [DW-1:0] data; } beat_t;
    beat_t                  en_q[$];
    int                     commit_q[$];
    logic [ROWS*DW-1:0]     tile_q[$];

    // Reference: handshake, row ordering into tiles, commit decisions.
    logic [DW-1:0] rows_acc[$];
    int            m_cnt = 0;
    bit            m_pending = 0;
    bit            prev_acc = 0;
    logic [31:0]   m_stall = '0;

    always @(negedge clk) begin
        bit m_ready, acc, m_busy;
        logic [ROWS*DW-1:0] tile;
        if (reset) begin
            rows_acc.delete();
            m_cnt = 0; m_pending = 0; prev_acc = 0; m_stall = '0;
            check("reset_outputs",
                  {wgt_ready, b_path_out, b_path_en_out, b_en_out, busy, tile_done}, '0);
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
            check("reset_stall_cnt", stall_cnt, 0);
`endif
        end else begin
            m_ready = !m_pending || commit_allow;
            m_busy  = (m_cnt != 0) || m_pending || prev_acc;
            check("wgt_ready", wgt_ready, m_ready);
            check("busy", busy, m_busy);
            acc = wgt_valid && m_ready;
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
            if (m_busy && !acc && !(m_pending && commit_allow) && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
`endif
            if (m_pending && commit_allow) begin
                commit_q.push_back(cyc + 1);
                m_pending = 0;
            end
            if (acc) begin
                en_q.push_back('{cyc + 1, wgt_data});
                rows_acc.push_back(wgt_data);
                m_cnt++;
                if (m_cnt == ROWS) begin
                    for (int r = 0; r < ROWS; r++) tile[r*DW +: DW] = rows_acc[ROWS-1-r];
                    tile_q.push_back(tile);
                    rows_acc.delete();
                    m_cnt = 0;
                    m_pending = 1;
                end
            end
            prev_acc = acc;
        end
    end

    // Monitor: PE-array model fed from DUT outputs, compared against queued expectations.
    logic [DW-1:0] pe_path [ROWS];
    logic [DW-1:0] pe_act  [ROWS];
    bit            en_prev = 0;
    bit            have_d  = 0;
    logic [DW-1:0] d_next  = '0;
    logic [DW-1:0] m_out   = '0;
    int            n_done  = 0;

    initial for (int r = 0; r < ROWS; r++) begin pe_path[r] = '0; pe_act[r] = '0; end

    always @(negedge clk) begin
        beat_t b;
        logic [ROWS*DW-1:0] got, exp_t;
        int cc;
        if (reset) begin
            en_q.delete(); commit_q.delete(); tile_q.delete();
            en_prev = 0; have_d = 0; m_out = '0;
        end else begin
            if (have_d) begin m_out = d_next; have_d = 0; end
            check("b_path_out", b_path_out, m_out);
            if (en_prev) begin
                for (int r = ROWS-1; r > 0; r--) pe_path[r] = pe_path[r-1];
                pe_path[0] = b_path_out;
            end
            if (b_path_en_out != '0) begin
                check("enable_all_bits", b_path_en_out, {COLS{1'b1}});
                if (en_q.size() == 0) begin
                    check("unexpected_enable", 1, 0);
                end else begin
                    b = en_q.pop_front();
                    check("enable_cycle", cyc, b.cyc);
                    d_next = b.data;
                    have_d = 1;
                end
            end else if (en_q.size() != 0 && en_q[0].cyc <= cyc) begin
                b = en_q.pop_front();
                check("missed_enable", 0, 1);
            end
            en_prev = (b_path_en_out != '0);
            if (tile_done || b_en_out != '0) begin
                n_done++;
                check("b_en_matches_done", b_en_out, {COLS{tile_done}});
                for (int r = 0; r < ROWS; r++) pe_act[r] = pe_path[r];
                if (commit_q.size() == 0 || tile_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    cc = commit_q.pop_front();
                    check("commit_cycle", cyc, cc);
                    exp_t = tile_q.pop_front();
                    for (int r = 0; r < ROWS; r++) got[r*DW +: DW] = pe_act[r];
                    check("pe_weights", got, exp_t);
                end
            end else if (commit_q.size() != 0 && commit_q[0] <= cyc) begin
                cc = commit_q.pop_front();
                if (tile_q.size() != 0) exp_t = tile_q.pop_front();
                check("missed_commit", 0, 1);
            end
        end
    end

    // Stimulus helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [DW-1:0] d);
        int k = 0;
        wgt_valid = 1'b1;
        wgt_data  = d;
        forever begin
            @(negedge clk);
            if (wgt_ready) break;
            k++;
            if (k > 200) begin
                check("handshake_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        wgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        wgt_valid = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        int done0;
        step(2);
        reset = 1'b0;
        step(1);

        // Tile 1: consecutive rows, commit always allowed.
        send_row(16'h0403); send_row(16'h0302); send_row(16'h0201); send_row(16'h0100);
        step(6);
        check("t1_row0_col0", pe_act[0][7:0], 8'h00);
        check("t1_row3_col0", pe_act[3][7:0], 8'h03);
        check("t1_row3_col1", pe_act[3][15:8], 8'h04);

        // Same tile with a 3-cycle gap mid-tile.
        send_row(16'h0403); send_row(16'h0302);
        step(3);
        send_row(16'h0201); send_row(16'h0100);
        step(6);
        check("t2_row0_col1", pe_act[0][15:8], 8'h01);
        check("t2_row2_col0", pe_act[2][7:0], 8'h02);

        // Two tiles back-to-back.
        for (int i = 0; i < 2*ROWS; i++) send_row(DW'($urandom));
        step(8);

        // Commit held off for 5 cycles after tile end, from a fresh reset.
        do_reset();
        for (int i = 0; i < ROWS; i++) send_row(DW'($urandom));
        commit_allow = 1'b0;
        step(5);
        commit_allow = 1'b1;
        step(4);
`ifdef WGT_PATH_LOADER_STALL_CNT_EN
        check("stall_cnt_backpressure", stall_cnt, 5);
`endif

        // Reset after two rows, then a full tile with exactly one commit.
        send_row(DW'($urandom)); send_row(DW'($urandom));
        do_reset();
        done0 = n_done;
        for (int i = 0; i < ROWS; i++) send_row(DW'($urandom));
        step(8);
        check("one_done_after_reset", n_done - done0, 1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            wgt_valid    = ($urandom_range(9) < 7);
            wgt_data     = DW'($urandom);
            commit_allow = ($urandom_range(9) < 6);
            step(1);
        end
        wgt_valid = 1'b0;
        commit_allow = 1'b1;
        step(10);

        check("en_q_drained", en_q.size(), 0);
        check("commit_q_drained", commit_q.size(), 0);
        check("tile_q_drained", tile_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
